// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared fp32 types, constants and helpers for the PE datapath
package fp_pkg;

    typedef struct packed {
        logic       sign;
        logic [7:0] exp;
        logic [22:0] man;
    } fp32_t;

    localparam int         FP_EXP_BIAS = 127;
    localparam logic [7:0] FP_EXP_MAX  = 8'hFF;
    localparam fp32_t      FP_POS_ZERO = '0;

    // Build a signed infinity.
    function automatic fp32_t fp_inf(input logic sign);
        fp32_t v;
        v.sign = sign;
        v.exp  = FP_EXP_MAX;
        v.man  = 23'd0;
        return v;
    endfunction

endpackage

// File: rtl/lzc24.sv
// rtl/lzc24.sv - combinational 24-bit leading-zero counter (24 for all-zero)
module lzc24 (
    input  logic [23:0] value,
    output logic [4:0]  count
);

    // Scan from LSB upward so the most significant set bit is the last to win.
    always_comb begin
        count = 5'd24;
        for (int i = 0; i < 24; i++) begin
            if (value[i]) begin
                count = 5'(23 - i);
            end
        end
    end

endmodule

// File: rtl/fp_add.sv
// rtl/fp_add.sv - four-stage fp32 adder: unpack/order, align, add, normalize
module fp_add
    import fp_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result,
    output logic        out_valid
);

    // ---------------- stage 1: unpack and order ----------------
    fp32_t       op_a, op_b;
    logic [23:0] man_a, man_b;
    logic        a_inf, b_inf, a_larger;

    assign op_a     = a;
    assign op_b     = b;
    assign man_a    = (op_a.exp == 8'd0) ? 24'd0 : {1'b1, op_a.man};
    assign man_b    = (op_b.exp == 8'd0) ? 24'd0 : {1'b1, op_b.man};
    assign a_inf    = (op_a.exp == FP_EXP_MAX);
    assign b_inf    = (op_b.exp == FP_EXP_MAX);
    assign a_larger = ({op_a.exp, man_a} >= {op_b.exp, man_b});

    logic        s1_valid, s1_sign, s1_sub, s1_inf, s1_inf_sign;
    logic [7:0]  s1_exp, s1_exp_diff;
    logic [23:0] s1_man_l, s1_man_s;

    // Register the ordered operands; infinity is resolved here and rides along.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid    <= 1'b0;
            s1_sign     <= 1'b0;
            s1_sub      <= 1'b0;
            s1_inf      <= 1'b0;
            s1_inf_sign <= 1'b0;
            s1_exp      <= 8'd0;
            s1_exp_diff <= 8'd0;
            s1_man_l    <= 24'd0;
            s1_man_s    <= 24'd0;
        end else begin
            s1_valid    <= in_valid;
            s1_sub      <= op_a.sign ^ op_b.sign;
            s1_inf      <= a_inf | b_inf;
            // Both infinite with opposite signs collapses to +inf.
            s1_inf_sign <= (a_inf && b_inf) ? (op_a.sign & op_b.sign)
                         : (a_inf ? op_a.sign : op_b.sign);
            if (a_larger) begin
                s1_sign     <= op_a.sign;
                s1_exp      <= op_a.exp;
                s1_exp_diff <= op_a.exp - op_b.exp;
                s1_man_l    <= man_a;
                s1_man_s    <= man_b;
            end else begin
                s1_sign     <= op_b.sign;
                s1_exp      <= op_b.exp;
                s1_exp_diff <= op_b.exp - op_a.exp;
                s1_man_l    <= man_b;
                s1_man_s    <= man_a;
            end
        end
    end

    // ---------------- stage 2: align ----------------
    logic        s2_valid, s2_sign, s2_sub, s2_inf, s2_inf_sign;
    logic [7:0]  s2_exp;
    logic [23:0] s2_man_l, s2_man_s;

    // Truncating right shift of the smaller mantissa.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_valid    <= 1'b0;
            s2_sign     <= 1'b0;
            s2_sub      <= 1'b0;
            s2_inf      <= 1'b0;
            s2_inf_sign <= 1'b0;
            s2_exp      <= 8'd0;
            s2_man_l    <= 24'd0;
            s2_man_s    <= 24'd0;
        end else begin
            s2_valid    <= s1_valid;
            s2_sign     <= s1_sign;
            s2_sub      <= s1_sub;
            s2_inf      <= s1_inf;
            s2_inf_sign <= s1_inf_sign;
            s2_exp      <= s1_exp;
            s2_man_l    <= s1_man_l;
            s2_man_s    <= (s1_exp_diff >= 8'd24) ? 24'd0 : (s1_man_s >> s1_exp_diff);
        end
    end

    // ---------------- stage 3: add ----------------
    logic              s3_valid, s3_sign, s3_inf, s3_inf_sign;
    logic signed [9:0] s3_exp;
    logic [24:0]       s3_sum;

    // Magnitude add/subtract; L >= S so the difference is never negative.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s3_valid    <= 1'b0;
            s3_sign     <= 1'b0;
            s3_inf      <= 1'b0;
            s3_inf_sign <= 1'b0;
            s3_exp      <= 10'sd0;
            s3_sum      <= 25'd0;
        end else begin
            s3_valid    <= s2_valid;
            s3_sign     <= s2_sign;
            s3_inf      <= s2_inf;
            s3_inf_sign <= s2_inf_sign;
            s3_exp      <= signed'({2'b00, s2_exp});
            s3_sum      <= s2_sub ? ({1'b0, s2_man_l} - {1'b0, s2_man_s})
                                  : ({1'b0, s2_man_l} + {1'b0, s2_man_s});
        end
    end

    // ---------------- stage 4: normalize and pack ----------------
    logic [4:0]        lz;
    logic signed [9:0] norm_exp;
    logic [22:0]       norm_man;
    fp32_t             packed_sum;

    lzc24 u_lzc (
        .value (s3_sum[23:0]),
        .count (lz)
    );

    // Normalize the sum and clamp the exponent to zero or infinity.
    always_comb begin
        norm_exp   = s3_exp;
        norm_man   = s3_sum[22:0];
        packed_sum = FP_POS_ZERO;
        if (s3_sum[24]) begin
            norm_exp = s3_exp + 10'sd1;
            norm_man = s3_sum[23:1];
        end else begin
            norm_exp = s3_exp - signed'({5'd0, lz});
            norm_man = s3_sum[22:0] << lz;
        end
        if (s3_inf) begin
            packed_sum = fp_inf(s3_inf_sign);
        end else if (s3_sum == 25'd0) begin
            packed_sum = FP_POS_ZERO;
        end else if (norm_exp >= 10'sd255) begin
            packed_sum = fp_inf(s3_sign);
        end else if (norm_exp <= 10'sd0) begin
            packed_sum      = FP_POS_ZERO;
            packed_sum.sign = s3_sign;
        end else begin
            packed_sum.sign = s3_sign;
            packed_sum.exp  = norm_exp[7:0];
            packed_sum.man  = norm_man;
        end
    end

    logic  s4_valid;
    fp32_t s4_value;

    // Stage-4 register, then the output register which only loads valid results.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s4_valid  <= 1'b0;
            s4_value  <= FP_POS_ZERO;
            out_valid <= 1'b0;
            result    <= 32'd0;
        end else begin
            s4_valid  <= s3_valid;
            s4_value  <= packed_sum;
            out_valid <= s4_valid;
            if (s4_valid) begin
                result <= s4_value;
            end
        end
    end

endmodule

// File: tb/tb_fp_add.sv
// tb/tb_fp_add.sv - randomized and directed self-checking bench for fp_add
module tb_fp_add;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic [31:0] result;
    logic        out_valid;

    int errors = 0;
    int checks = 0;

    // expected pipeline contents, index 1 = just captured
    logic        mv [1:4];
    logic [31:0] mr [1:4];
    logic        mout_v = 1'b0;
    logic [31:0] mout_r = 32'd0;

    fp_add dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .result    (result),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, expv);
        end
    endtask

    // Reference: integer mantissa arithmetic following the number-format rules.
    function automatic logic [31:0] fp_ref(input logic [31:0] x, input logic [31:0] y);
        int     ex, ey, el, es, d, e;
        longint mx, my, ml, ms, sum;
        logic   sx, sy, sl, ss;
        logic [31:0] r;
        sx = x[31]; ex = int'(x[30:23]);
        sy = y[31]; ey = int'(y[30:23]);
        mx = (ex == 0) ? 0 : (longint'(x[22:0]) + 64'd8388608);
        my = (ey == 0) ? 0 : (longint'(y[22:0]) + 64'd8388608);
        if (ex == 255 || ey == 255) begin
            if (ex == 255 && ey == 255 && sx != sy) return 32'h7F800000;
            return {(ex == 255) ? sx : sy, 8'hFF, 23'd0};
        end
        if (longint'(ex) * 16777216 + mx >= longint'(ey) * 16777216 + my) begin
            sl = sx; el = ex; ml = mx; ss = sy; es = ey; ms = my;
        end else begin
            sl = sy; el = ey; ml = my; ss = sx; es = ex; ms = mx;
        end
        d = el - es;
        ms = (d >= 24) ? 0 : (ms >> d);
        sum = (sl == ss) ? ml + ms : ml - ms;
        if (sum == 0) return 32'h0;
        e = el;
        while (sum >= 16777216) begin sum = sum >> 1; e++; end
        while (sum < 8388608) begin sum = sum << 1; e--; end
        if (e >= 255) return {sl, 8'hFF, 23'd0};
        if (e <= 0) return {sl, 31'd0};
        r = {sl, 8'(e), 23'(sum)};
        return r;
    endfunction

    function automatic logic [31:0] rand_fp(input int near);
        int k, e;
        k = int'($urandom_range(0, 15));
        if (k == 0) return {1'($urandom), 8'd0, 23'($urandom)};
        if (k == 1) return {1'($urandom), 8'hFF, 23'($urandom)};
        if (k == 2) return {1'($urandom), 8'hFE, 23'($urandom)};
        if (k < 10) e = near + int'($urandom_range(0, 6)) - 3;
        else        e = int'($urandom_range(1, 254));
        if (e < 1) e = 1;
        if (e > 254) e = 254;
        return {1'($urandom), 8'(e), 23'($urandom)};
    endfunction

    task automatic model_clear();
        for (int i = 1; i <= 4; i++) begin mv[i] = 1'b0; mr[i] = 32'd0; end
        mout_v = 1'b0;
        mout_r = 32'd0;
    endtask

    // One clock: drive at negedge, advance model on posedge, compare at next negedge.
    task automatic step(input logic v, input logic [31:0] x, input logic [31:0] y);
        in_valid = v; a = x; b = y;
        @(posedge clk);
        if (!rst) begin
            model_clear();
        end else begin
            mout_v = mv[4];
            if (mv[4]) mout_r = mr[4];
            for (int i = 4; i >= 2; i--) begin mv[i] = mv[i-1]; mr[i] = mr[i-1]; end
            mv[1] = v;
            mr[1] = fp_ref(x, y);
        end
        @(negedge clk);
        check("out_valid", {31'd0, out_valid}, {31'd0, mout_v});
        check("result", result, mout_r);
    endtask

    task automatic run_pair(input string tag, input logic [31:0] x, input logic [31:0] y,
                            input logic [31:0] expv);
        step(1'b1, x, y);
        repeat (4) step(1'b0, 32'd0, 32'd0);
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check(tag, result, expv);
    endtask

    initial begin
        model_clear();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_result", result, 32'd0);
        check("reset_valid", {31'd0, out_valid}, 32'd0);
        rst = 1'b1;

        run_pair("one_plus_one", 32'h3F800000, 32'h3F800000, 32'h40000000);
        step(1'b0, 32'd0, 32'd0);
        check("one_plus_one_hold", result, 32'h40000000);
        run_pair("cancel", 32'h3FC00000, 32'hBFC00000, 32'h00000000);
        run_pair("lnorm", 32'h40400000, 32'hBF800000, 32'h40000000);
        run_pair("align_loss", 32'h3F800000, 32'h30800000, 32'h3F800000);
        run_pair("overflow", 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000);
        run_pair("inf_plus", 32'h7F800000, 32'hBF800000, 32'h7F800000);
        run_pair("inf_opp", 32'hFF800000, 32'h7F800000, 32'h7F800000);
        run_pair("neg_inf", 32'h3F800000, 32'hFF800000, 32'hFF800000);

        // back-to-back stream with a bubble
        step(1'b1, 32'h3F800000, 32'h3F800000);
        step(1'b1, 32'h40000000, 32'h40000000);
        step(1'b0, 32'd0, 32'd0);
        step(1'b1, 32'hC0000000, 32'h3F800000);
        step(1'b0, 32'd0, 32'd0);
        check("b2b_0", result, 32'h40000000);
        check("b2b_0_valid", {31'd0, out_valid}, 32'd1);
        step(1'b0, 32'd0, 32'd0);
        check("b2b_1", result, 32'h40800000);
        step(1'b0, 32'd0, 32'd0);
        check("b2b_gap_valid", {31'd0, out_valid}, 32'd0);
        step(1'b0, 32'd0, 32'd0);
        check("b2b_3", result, 32'hBF800000);
        check("b2b_3_valid", {31'd0, out_valid}, 32'd1);

        // reset while three operations are in flight
        step(1'b1, 32'h3F800000, 32'h3F800000);
        step(1'b1, 32'h40000000, 32'h40000000);
        step(1'b1, 32'h40400000, 32'h40400000);
        step(1'b1, 32'h40800000, 32'h40800000);
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("rst_mid_result", result, 32'd0);
        check("rst_mid_valid", {31'd0, out_valid}, 32'd0);
        step(1'b0, 32'd0, 32'd0);
        rst = 1'b1;
        repeat (5) step(1'b0, 32'd0, 32'd0);
        run_pair("after_reset", 32'h40000000, 32'h3F800000, 32'h40400000);

        // randomized stream against the reference model
        for (int n = 0; n < 600; n++) begin
            logic [31:0] x;
            x = rand_fp(127);
            step(($urandom_range(0, 3) != 0), x, rand_fp(int'(x[30:23])));
        end
        repeat (5) step(1'b0, 32'd0, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
